// File: rtl/cpu_hatch_loader_pkg.sv
// Shared definitions for the instruction hatch: FSM encoding, word geometry
// and the small decode helpers used by the loader.
package cpu_hatch_loader_pkg;

  localparam int INSN_W         = 48;
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 6;

  localparam logic [2:0] ST_HOLD    = 3'd0;
  localparam logic [2:0] ST_HDR0    = 3'd1;
  localparam logic [2:0] ST_HDR1    = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_RUN     = 3'd5;

  // States in which the byte stream is consumed.
  function automatic logic st_accepts(input logic [2:0] st);
    return (st == ST_HDR0) || (st == ST_HDR1) || (st == ST_DATA);
  endfunction

  function automatic logic st_busy(input logic [2:0] st);
    return st_accepts(st) || (st == ST_RELEASE);
  endfunction

endpackage

// File: rtl/cpu_hatch_ram.sv
// Single-write, single-read synchronous RAM with a registered read port,
// shaped so that synthesis maps it onto block RAM.
module cpu_hatch_ram
  import cpu_hatch_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = INSN_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write port; contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_hatch_loader.sv
// Instruction hatch in front of the CPU fetch stage: serves 48-bit words and
// loads programs from a byte stream while holding the CPU in reset.
module cpu_hatch_loader
  import cpu_hatch_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [31:0]       hatch_address,
  output logic [INSN_W-1:0] hatch_instruction,
  input  logic              load_start,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              cpu_rst_b,
  output logic              load_busy,
  output logic              load_err
);

  localparam int unsigned     DEPTH       = 2**ADDR_W;
  localparam logic [2:0]      RESET_STATE = BOOT_HOLD ? ST_HOLD : ST_RUN;
  localparam logic [ADDR_W:0] WI_ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [2:0]      LAST_BYTE   = 3'(BYTES_PER_WORD - 1);

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       rcv_q, rcv_d;
  logic [ADDR_W:0]   wi_q, wi_d;
  logic [2:0]        bi_q, bi_d;
  logic [INSN_W-9:0] asm_q, asm_d;
  logic              err_q, err_d;
  logic              ready_q, busy_q, cpu_rst_q, zero_q;

  logic              accept_s;
  logic [15:0]       hdr_count_s;
  logic              we_s;
  logic [INSN_W-1:0] wdata_s;
  logic [INSN_W-1:0] ram_rdata_s;

  assign accept_s    = load_valid && ready_q;
  assign hdr_count_s = {count_q[15:8], load_byte};
  assign wdata_s     = {asm_q, load_byte};

  // Load FSM, header capture and big-endian word assembly.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rcv_d   = rcv_q;
    wi_d    = wi_q;
    bi_d    = bi_q;
    asm_d   = asm_q;
    err_d   = err_q;
    we_s    = 1'b0;
    if (load_start) begin
      state_d = ST_HDR0;
      err_d   = 1'b0;
      wi_d    = '0;
      bi_d    = 3'd0;
      rcv_d   = 16'd0;
      asm_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD, ST_RUN: begin
          state_d = state_q;
        end
        ST_HDR0: begin
          if (accept_s) begin
            count_d[15:8] = load_byte;
            state_d       = ST_HDR1;
          end else begin
            state_d = ST_HDR0;
          end
        end
        ST_HDR1: begin
          if (accept_s) begin
            count_d = hdr_count_s;
            if ({16'd0, hdr_count_s} > 32'(DEPTH)) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            state_d = (hdr_count_s == 16'd0) ? ST_RELEASE : ST_DATA;
          end else begin
            state_d = ST_HDR1;
          end
        end
        ST_DATA: begin
          if (accept_s) begin
            asm_d = wdata_s[INSN_W-9:0];
            if (bi_q == LAST_BYTE) begin
              // Words past the RAM depth are consumed but never written.
              we_s  = ~wi_q[ADDR_W];
              wi_d  = wi_q[ADDR_W] ? wi_q : (wi_q + WI_ONE);
              bi_d  = 3'd0;
              rcv_d = rcv_q + 16'd1;
              if (rcv_d == count_q) begin
                state_d = ST_RELEASE;
              end else begin
                state_d = ST_DATA;
              end
            end else begin
              bi_d = bi_q + 3'd1;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_RELEASE: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = RESET_STATE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= RESET_STATE;
      count_q <= 16'd0;
      rcv_q   <= 16'd0;
      wi_q    <= '0;
      bi_q    <= 3'd0;
      asm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rcv_q   <= rcv_d;
      wi_q    <= wi_d;
      bi_q    <= bi_d;
      asm_q   <= asm_d;
      err_q   <= err_d;
    end
  end

  // Status outputs are decoded from the next state so they change together with it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      cpu_rst_q <= ~BOOT_HOLD;
      zero_q    <= 1'b1;
    end else begin
      ready_q   <= st_accepts(state_d);
      busy_q    <= st_busy(state_d);
      cpu_rst_q <= (state_d == ST_RUN);
      zero_q    <= (|hatch_address[31:ADDR_W]) || (state_d != ST_RUN);
    end
  end

  cpu_hatch_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (INSN_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we_s),
    .waddr_i (wi_q[ADDR_W-1:0]),
    .wdata_i (wdata_s),
    .raddr_i (hatch_address[ADDR_W-1:0]),
    .rdata_o (ram_rdata_s)
  );

  assign hatch_instruction = zero_q ? '0 : ram_rdata_s;
  assign load_ready        = ready_q;
  assign load_busy         = busy_q;
  assign cpu_rst_b         = cpu_rst_q;
  assign load_err          = err_q;

endmodule

// File: tb/tb_cpu_hatch_loader.sv
// Directed bench for cpu_hatch_loader with a 4-word RAM: expected reads are
// queued when an address is presented and compared one cycle later.
module tb_cpu_hatch_loader;
  import cpu_hatch_loader_pkg::*;

  localparam int AW = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] hatch_address;
  logic [47:0] hatch_instruction;
  logic        load_start;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_ready;
  logic        cpu_rst_b;
  logic        load_busy;
  logic        load_err;

  int tests = 0;
  int fails = 0;
  logic [47:0] exp_q [$];
  logic [47:0] ov_w [5];
  logic [47:0] gap_w [3];

  always #5 clk = ~clk;

  cpu_hatch_loader #(.ADDR_W(AW), .BOOT_HOLD(1'b1)) dut (
    .clk               (clk),
    .rst_b             (rst_b),
    .hatch_address     (hatch_address),
    .hatch_instruction (hatch_instruction),
    .load_start        (load_start),
    .load_byte         (load_byte),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .cpu_rst_b         (cpu_rst_b),
    .load_busy         (load_busy),
    .load_err          (load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      for (int n = 0; n < 6 && $urandom_range(0, 1) == 1; n++) begin
        load_valid = 1'b0;
        load_byte  = 8'($urandom);
        tick();
      end
    end
    load_valid = 1'b1;
    load_byte  = b;
    check("byte_ready", 48'(load_ready), 48'd1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [47:0] w, input bit gaps);
    for (int j = 0; j < BYTES_PER_WORD; j++) send(w[47-8*j -: 8], gaps);
  endtask

  task automatic start_load(input logic [15:0] cnt, input bit gaps);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("start_busy", 48'(load_busy), 48'd1);
    check("start_cpu_rst", 48'(cpu_rst_b), 48'd0);
    check("start_err_clr", 48'(load_err), 48'd0);
    for (int i = 0; i < HDR_BYTES; i++) send((i == 0) ? cnt[15:8] : cnt[7:0], gaps);
  endtask

  // Called right after the edge that accepted the final byte.
  task automatic finish_check(input string tag);
    check({tag, "_release_rst"}, 48'(cpu_rst_b), 48'd0);
    check({tag, "_release_busy"}, 48'(load_busy), 48'd1);
    check({tag, "_release_ready"}, 48'(load_ready), 48'd0);
    tick();
    check({tag, "_run_rst"}, 48'(cpu_rst_b), 48'd1);
    check({tag, "_run_busy"}, 48'(load_busy), 48'd0);
  endtask

  task automatic read(input logic [31:0] a, input logic [47:0] e);
    logic [47:0] want;
    hatch_address = a;
    exp_q.push_back(e);
    tick();
    want = exp_q.pop_front();
    check($sformatf("read@%h", a), hatch_instruction, want);
  endtask

  initial begin
    rst_b         = 1'b0;
    hatch_address = 32'd0;
    load_start    = 1'b0;
    load_byte     = 8'd0;
    load_valid    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ov_w[k] = 48'd0;
      for (int j = 0; j < 6; j++) ov_w[k] = {ov_w[k][39:0], 8'((k << 4) | (j + 1))};
    end
    gap_w[0] = 48'hC0FFEE_123456;
    gap_w[1] = 48'h0F1E2D_3C4B5A;
    gap_w[2] = 48'hFEDCBA_987654;

    // Boot hold with no load.
    repeat (3) tick();
    rst_b = 1'b1;
    check("reset_busy", 48'(load_busy), 48'd0);
    check("reset_err", 48'(load_err), 48'd0);
    for (int c = 0; c < 100; c++) begin
      hatch_address = 32'(c % 4);
      tick();
      check("hold_cpu_rst", 48'(cpu_rst_b), 48'd0);
      check("hold_insn", hatch_instruction, 48'd0);
      check("hold_ready", 48'(load_ready), 48'd0);
    end

    // Two-word load.
    start_load(16'd2, 1'b0);
    send_word(48'h112233445566, 1'b0);
    send_word(48'hAABBCCDDEEFF, 1'b0);
    finish_check("load2");
    check("load2_err", 48'(load_err), 48'd0);
    read(32'd0, 48'h112233445566);
    read(32'd1, 48'hAABBCCDDEEFF);
    read(32'd4, 48'd0);
    read(32'h8000_0001, 48'd0);
    read(32'd1, 48'hAABBCCDDEEFF);

    // Empty program.
    start_load(16'd0, 1'b0);
    finish_check("empty");
    check("empty_err", 48'(load_err), 48'd0);
    read(32'd0, 48'h112233445566);

    // Header count larger than the RAM.
    start_load(16'd5, 1'b0);
    check("ovf_err_hdr", 48'(load_err), 48'd1);
    for (int k = 0; k < 5; k++) send_word(ov_w[k], 1'b0);
    finish_check("ovf");
    check("ovf_err_sticky", 48'(load_err), 48'd1);
    for (int k = 0; k < 4; k++) read(32'(k), ov_w[k]);

    // Bytes offered in RUN are ignored.
    for (int c = 0; c < 5; c++) begin
      load_valid = 1'b1;
      load_byte  = 8'h5A;
      tick();
      check("run_ready", 48'(load_ready), 48'd0);
      check("run_cpu_rst", 48'(cpu_rst_b), 48'd1);
    end
    load_valid = 1'b0;

    // Three-word load with random valid gaps.
    start_load(16'd3, 1'b1);
    for (int k = 0; k < 3; k++) send_word(gap_w[k], 1'b1);
    finish_check("gap");
    check("gap_err", 48'(load_err), 48'd0);
    for (int k = 0; k < 3; k++) read(32'(k), gap_w[k]);
    read(32'd3, ov_w[3]);

    // Restart after a partial word.
    start_load(16'd1, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    send(8'hBE, 1'b0);
    start_load(16'd1, 1'b0);
    send_word(48'h010203040506, 1'b0);
    finish_check("restart");
    read(32'd0, 48'h010203040506);
    read(32'd1, gap_w[1]);

    // Reset in the middle of DATA.
    start_load(16'd2, 1'b0);
    send(8'h99, 1'b0);
    send(8'h88, 1'b0);
    send(8'h77, 1'b0);
    #2;
    rst_b = 1'b0;
    #1;
    check("midrst_ready", 48'(load_ready), 48'd0);
    check("midrst_busy", 48'(load_busy), 48'd0);
    check("midrst_cpu_rst", 48'(cpu_rst_b), 48'd0);
    tick();
    rst_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      load_valid = 1'b1;
      load_byte  = 8'h00;
      tick();
      check("post_rst_ready", 48'(load_ready), 48'd0);
      check("post_rst_cpu_rst", 48'(cpu_rst_b), 48'd0);
      check("post_rst_busy", 48'(load_busy), 48'd0);
    end
    load_valid = 1'b0;
    start_load(16'd0, 1'b0);
    finish_check("after_rst");
    read(32'd0, 48'h010203040506);
    read(32'd1, gap_w[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_hatch_loader.md
Name: cpu_hatch_loader

Overview:
Instruction-memory "hatch" that sits directly upstream of the CPU's fetch stage. It serves 48-bit instruction words on hatch_instruction for the word address the CPU drives on hatch_address. It also accepts a byte stream (from a UART/host bridge), assembles it into instructions, writes them into its instruction RAM, and holds the CPU in reset while a program is loaded.

Parameters:
ADDR_W, 10, instruction RAM word-address width; depth = 2**ADDR_W words of 48 bits
BOOT_HOLD, 1, 1: hold the CPU in reset after rst_b until the first load completes; 0: release the CPU immediately

Ports:
clk  input  1  system clock
rst_b  input  1  asynchronous active-low reset
hatch_address  input  32  word address from the CPU fetch stage
hatch_instruction  output  48  instruction word for the CPU
load_start  input  1  one-cycle pulse that begins (or restarts) a program load
load_byte  input  8  load stream data byte
load_valid  input  1  load_byte is valid
load_ready  output  1  loader accepts a byte this cycle
cpu_rst_b  output  1  active-low reset to the CPU
load_busy  output  1  a load is in progress
load_err  output  1  sticky: the last load's header count exceeded the RAM depth

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_b is asynchronous and active-low.
- Reset values:
  - state = HOLD if BOOT_HOLD=1, otherwise RUN
  - hatch_instruction = 0, load_ready = 0, load_busy = 0, load_err = 0
  - cpu_rst_b = 0 if BOOT_HOLD=1, otherwise 1
  - RAM contents are not reset.
- States: HOLD, HDR0, HDR1, DATA, RELEASE, RUN.
- Byte acceptance: a byte is accepted when load_valid && load_ready. load_ready = 1 only in HDR0, HDR1 and DATA.
- Transitions:
  - HOLD/RUN --load_start--> HDR0. Clear load_err, word index, and byte index.
  - HDR0 --accept--> HDR1. The byte is count[15:8].
  - HDR1 --accept--> DATA, or --accept--> RELEASE if the 16-bit count == 0. The byte is count[7:0]. If count > 2**ADDR_W, set load_err.
  - DATA: each accepted byte shifts into a 48-bit assembly register, big-endian (first byte = bits 47:40).
    - On the 6th byte, write the word to RAM[word index] only if word index < 2**ADDR_W. Then increment word index and reset byte index.
    - Words beyond the RAM depth are consumed but dropped.
    - After the count-th word has been written, go to RELEASE.
  - RELEASE → RUN after exactly one cycle.
- load_start in any state restarts at HDR0 with the same clears. A partially assembled word is discarded, but words already written remain in RAM.
- cpu_rst_b:
  - 0 in HOLD, HDR0, HDR1, DATA and RELEASE; 1 in RUN.
  - It is driven from a flop, so the CPU comes out of reset on the clock edge that enters RUN.
  - The RELEASE cycle guarantees the final RAM write has completed before the CPU's first fetch.
- load_busy = 1 in HDR0, HDR1, DATA and RELEASE.
- Read port:
  - Synchronous, 1-cycle latency: hatch_instruction at cycle N+1 = RAM[hatch_address[ADDR_W-1:0]] sampled at N.
  - Returns 48'h0 if hatch_address[31:ADDR_W] != 0.
  - Returns 48'h0 whenever cpu_rst_b = 0.
  - Read-during-write is not possible, because the CPU is held in reset throughout a load.
- Arithmetic: the word index is ADDR_W+1 bits and saturates at 2**ADDR_W. The received-word counter is 16 bits and is compared with count. load_valid without load_ready is ignored, with no side effect.
- Reset mid-load: the FSM aborts to its reset state and RAM keeps any partially loaded contents.

Decomposition:
- Shared package: state encoding, the INSN_W=48 constant, the header byte count (2) and bytes per word (6).
- One sub-module: cpu_hatch_ram, a 48-bit-wide single-write-port, single-read-port synchronous RAM with registered read and depth 2**ADDR_W, so it infers block RAM.
- The FSM, assembler and address decode stay in cpu_hatch_loader.

Test Plan:
- Reset with BOOT_HOLD=1 and no load → cpu_rst_b=0, hatch_instruction=0, load_ready=0 for 100 cycles.
- load_start, then bytes 00 02 | 11 22 33 44 55 66 | AA BB CC DD EE FF → cpu_rst_b rises exactly 2 cycles after the last accepted byte. Address 0 then reads 0x112233445566 and address 1 reads 0xAABBCCDDEEFF, each 1 cycle after the address is presented. Address 2**ADDR_W reads 0.
- Header 00 00 → RELEASE then RUN, with cpu_rst_b=1 two cycles after the second header byte. load_err=0.
- With ADDR_W=2, header 00 05 plus 30 data bytes → load_err=1 and all 30 bytes are accepted. Words 0–3 are written and word 4 is dropped. After RUN, address 0 still holds word 0.
- Random load_valid gaps (50% duty) on a 3-word load → same RAM contents as the gap-free load. No byte is accepted while load_ready=0.
- load_start pulsed after 3 data bytes, then a full 1-word load of 0x0102030405 06 → RAM[0]=0x010203040506. Also, rst_b asserted mid-DATA → load_ready drops asynchronously and the FSM returns to HOLD.
